// File: rtl/norm_packer_if.sv
// norm_packer_if: word stream in, packed vector handshake out, plus overflow flag.
interface norm_packer_if #(
  parameter int W_OUT = 16,
  parameter int COL   = 8
);
  logic                 norm_valid;
  logic [W_OUT-1:0]     psum_norm;
  logic                 m_valid;
  logic                 m_ready;
  logic [COL*W_OUT-1:0] m_data;
  logic                 ovf;
  modport master (output norm_valid, psum_norm, m_ready, input m_valid, m_data, ovf);
  modport slave  (input norm_valid, psum_norm, m_ready, output m_valid, m_data, ovf);
endinterface

// File: rtl/norm_packer.sv
// norm_packer: packs serial normalized words (lane 0 first) into COL-lane vectors via two ping-pong buffers.
// Define NORM_PACKER_OVF_DETECT_EN for a sticky ovf flag on dropped words; otherwise ovf is tied to 0.
module norm_packer #(
  parameter int BW_PSUM = 16,
  parameter int COL     = 8,
  parameter int W_OUT   = BW_PSUM
) (
  input  logic         clk,
  input  logic         reset_n,
  norm_packer_if.slave bus
);
  localparam int CW = $clog2(COL);
  localparam logic [CW-1:0] LAST = CW'(COL - 1);
  logic [1:0][COL*W_OUT-1:0] r_buf;
  logic [1:0]                r_full;
  logic                      r_wsel;
  logic                      r_rsel;
  logic [CW-1:0]             r_col;
  logic                      w_acc;
  logic                      w_fill;
  logic                      w_drain;
  // The write buffer can only be full when both are, so this alone gates drops.
  assign w_acc   = bus.norm_valid && !r_full[r_wsel];
  assign w_fill  = w_acc && (r_col == LAST);
  assign w_drain = bus.m_valid && bus.m_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf  <= '0;
      r_full <= '0;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_col  <= '0;
    end else begin
      if (w_acc) begin
        r_buf[r_wsel][r_col*W_OUT +: W_OUT] <= bus.psum_norm;
        r_col <= w_fill ? '0 : r_col + 1'b1;
      end
      if (w_fill) r_wsel <= ~r_wsel;
      if (w_drain) r_rsel <= ~r_rsel;
      r_full <= (r_full & ~({1'b0, w_drain} << r_rsel)) | ({1'b0, w_fill} << r_wsel);
    end
  end
  assign bus.m_valid = r_full[r_rsel];
  assign bus.m_data  = r_buf[r_rsel];
`ifdef NORM_PACKER_OVF_DETECT_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ovf <= 1'b0;
    else if (bus.norm_valid && r_full[r_wsel]) r_ovf <= 1'b1;
  end
  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule
